// File: rtl/pipe_stage_latch_pkg.sv
// Shared pipeline definitions: default field widths and write-back control bit positions.
package pipe_stage_latch_pkg;

  localparam int CTRL_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Write-back control field bit positions.
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  function automatic int payload_w(input int ctrl_w, input int data_w, input int reg_w);
    return ctrl_w + 2 * data_w + reg_w;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with synchronous load and clear; clear wins over load.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Two-entry skid-buffered pipeline latch between memory and write-back.
module pipe_stage_latch
  import pipe_stage_latch_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  rw_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  rw_out,
  output logic [1:0]        occupancy
);

  localparam int PW = payload_w(CTRL_W, DATA_W, REG_W);

  logic          main_valid, skid_valid, in_ready_q;
  logic [1:0]    occ_q;
  logic [PW-1:0] in_pl, main_pl, skid_pl, main_d;
  logic          in_xfer, out_xfer, move_skid, load_main, load_skid;
  logic          main_n, skid_n, main_ld, main_clr, skid_clr;

  assign in_pl = {ctrl_in, mem_in, alu_in, rw_in};

  always_comb begin
    in_xfer   = in_valid & in_ready_q;
    out_xfer  = main_valid & out_ready;
    move_skid = out_xfer & skid_valid;
    // in_xfer implies the skid is empty, so a draining main can take the new beat directly.
    load_main = in_xfer & (~main_valid | out_xfer);
    load_skid = in_xfer & main_valid & ~out_xfer;
    main_n    = move_skid | load_main | (main_valid & ~out_xfer);
    skid_n    = load_skid | (skid_valid & ~out_xfer);
    if (flush) begin
      main_n = 1'b0;
      skid_n = 1'b0;
    end
    main_ld  = load_main | move_skid;
    main_d   = move_skid ? skid_pl : in_pl;
    // Zeroing main whenever it goes empty keeps ctrl_out a bubble while out_valid is low.
    main_clr = ~main_n;
    skid_clr = flush | move_skid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      main_valid <= main_n;
      skid_valid <= skid_n;
      in_ready_q <= ~skid_n;
      occ_q      <= {1'b0, main_n} + {1'b0, skid_n};
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clock (clock),
    .reset (reset),
    .clear (main_clr),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_pl)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clock (clock),
    .reset (reset),
    .clear (skid_clr),
    .load  (load_skid),
    .d     (in_pl),
    .q     (skid_pl)
  );

  assign {ctrl_out, mem_out, alu_out, rw_out} = main_pl;
  assign out_valid = main_valid;
  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: queue-based reference model with directed and random stimulus.
module tb_pipe_stage_latch;

  localparam int CW = 2;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] ctrl_in = '0;
  logic [DW-1:0] mem_in = '0;
  logic [DW-1:0] alu_in = '0;
  logic [RW-1:0] rw_in = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] mem_out, alu_out;
  logic [RW-1:0] rw_out;
  logic [1:0]    occupancy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [RW-1:0] rw;
  } beat_t;

  beat_t q[$];

  pipe_stage_latch #(.CTRL_W(CW), .DATA_W(DW), .REG_W(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_in   (ctrl_in),
    .mem_in    (mem_in),
    .alu_in    (alu_in),
    .rw_in     (rw_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_out  (ctrl_out),
    .mem_out   (mem_out),
    .alu_out   (alu_out),
    .rw_out    (rw_out),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  // Reference: an in-order FIFO of capacity two; acceptance is decided by the size before the edge.
  task automatic cycle();
    bit can_take;
    beat_t b;
    @(posedge clock);
    b = beat_t'({ctrl_in, mem_in, alu_in, rw_in});
    if (reset || flush) begin
      q.delete();
    end else begin
      can_take = (q.size() < 2);
      if (out_ready && q.size() > 0) q.delete(0);
      if (in_valid && can_take) q.push_back(b);
    end
    #1;
  endtask

  function automatic logic [5:0] exp_status();
    logic [CW-1:0] c;
    c = (q.size() > 0) ? q[0].ctrl : '0;
    return {q.size() > 0, q.size() < 2, 2'(q.size()), c};
  endfunction

  function automatic logic [5:0] obs_status();
    return {out_valid, in_ready, occupancy, ctrl_out};
  endfunction

  task automatic set_beat(input logic [CW-1:0] c, input logic [DW-1:0] m,
                          input logic [DW-1:0] a, input logic [RW-1:0] r);
    ctrl_in = c; mem_in = m; alu_in = a; rw_in = r;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    set_beat(2'b11, 32'hAAAA_5555, 32'h1234_5678, 5'd7);
    cycle();
    cycle();
    total++;
    if (obs_status() !== 6'b0_1_00_00) begin
      bad++; $display("FAIL reset_status got=%b want=%b", obs_status(), 6'b0_1_00_00);
    end
    total++;
    if ({mem_out, alu_out, rw_out} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", mem_out, alu_out, rw_out);
    end
    reset = 1'b0; in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      set_beat(2'b11, $urandom, 32'h10 + i, 5'($urandom));
      cycle();
      total++;
      if (!out_valid || alu_out !== 32'h10 + i || occupancy !== 2'd1 || ctrl_out !== 2'b11) begin
        bad++; $display("FAIL b2b_beat%0d got v=%b alu=%h occ=%0d ctrl=%b want v=1 alu=%h occ=1 ctrl=11",
                        i, out_valid, alu_out, occupancy, ctrl_out, 32'h10 + i);
      end
      total++;
      if (obs_status() !== exp_status()) begin
        bad++; $display("FAIL b2b_status%0d got=%b want=%b", i, obs_status(), exp_status());
      end
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (obs_status() !== exp_status()) begin
      bad++; $display("FAIL b2b_drain got=%b want=%b", obs_status(), exp_status());
    end
  endtask

  task automatic test_backpressure();
    int exp_occ[3] = '{1, 2, 2};
    bit exp_rdy[3] = '{1'b1, 1'b0, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_beat(2'(i + 1), $urandom, 32'h20 + i, 5'(i));
      cycle();
      total++;
      if (occupancy !== 2'(exp_occ[i]) || in_ready !== exp_rdy[i] || alu_out !== 32'h20) begin
        bad++; $display("FAIL bp_fill%0d got occ=%0d rdy=%b alu=%h want occ=%0d rdy=%b alu=20",
                        i, occupancy, in_ready, alu_out, exp_occ[i], exp_rdy[i]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    total++;
    if (alu_out !== 32'h21 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      bad++; $display("FAIL bp_drain1 got alu=%h rdy=%b occ=%0d want alu=21 rdy=1 occ=1",
                      alu_out, in_ready, occupancy);
    end
    cycle();
    total++;
    if (obs_status() !== exp_status() || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain2 got=%b want=%b", obs_status(), exp_status());
    end
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      set_beat(2'b10, $urandom, 32'h30 + i, 5'(i + 3));
      cycle();
    end
    total++;
    if (occupancy !== 2'd2 || obs_status() !== exp_status()) begin
      bad++; $display("FAIL fill_two got=%b want=%b", obs_status(), exp_status());
    end
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1; in_valid = 1'b1;
    set_beat(2'b11, 32'hDEAD, 32'hDEAD, 5'd31);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (obs_status() !== 6'b0_1_00_00) begin
      bad++; $display("FAIL flush_status got=%b want=%b", obs_status(), 6'b0_1_00_00);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (out_valid !== 1'b0 || obs_status() !== exp_status()) begin
        bad++; $display("FAIL flush_ghost%0d got v=%b alu=%h want v=0", i, out_valid, alu_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_two();
    reset = 1'b1; in_valid = 1'b1;
    set_beat(2'b01, 32'hBEEF, 32'hBEEF, 5'd9);
    cycle();
    total++;
    if ({out_valid, in_ready, occupancy, ctrl_out, mem_out, alu_out, rw_out} !==
        {1'b0, 1'b1, 2'd0, {CW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, {RW{1'b0}}}) begin
      bad++; $display("FAIL reset_mid got v=%b rdy=%b occ=%0d ctrl=%b mem=%h alu=%h rw=%h want all zero rdy=1",
                      out_valid, in_ready, occupancy, ctrl_out, mem_out, alu_out, rw_out);
    end
    reset = 1'b0; in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] seq = 32'h1000;
    logic ir;
    for (int n = 0; n < 10000; n++) begin
      in_valid = ($urandom_range(99) < 70);
      flush = ($urandom_range(299) == 0);
      set_beat(2'($urandom), $urandom, seq, 5'($urandom));
      seq++;
      out_ready = ($urandom_range(99) < 60);
      ir = in_ready;
      out_ready = ~out_ready;
      #1;
      total++;
      if (in_ready !== ir) begin
        bad++; $display("FAIL rand_ready_comb%0d got=%b want=%b", n, in_ready, ir);
      end
      out_ready = ~out_ready;
      cycle();
      total++;
      if (obs_status() !== exp_status()) begin
        bad++; $display("FAIL rand_status%0d got=%b want=%b", n, obs_status(), exp_status());
      end
      if (q.size() > 0) begin
        total++;
        if ({mem_out, alu_out, rw_out} !== {q[0].mem, q[0].alu, q[0].rw}) begin
          bad++; $display("FAIL rand_data%0d got=%h/%h/%h want=%h/%h/%h", n,
                          mem_out, alu_out, rw_out, q[0].mem, q[0].alu, q[0].rw);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
